// File: rtl/serial_alu.sv
// ============================================================================
// Module   : serial_alu
// Brief    : Bit-serial ALU stage, LSB-first operands and result, N-cycle ops
//            with registered condition flags presented at completion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_alu #(
   parameter int N = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic       a_bit,
   input  logic       b_bit,
   output logic       ready,
   output logic       r_bit,
   output logic       r_valid,
   output logic       done,
   output logic       flag_z,
   output logic       flag_n,
   output logic       flag_c,
   output logic       flag_v,
   output logic       flag_lt
);

   localparam int CW = $clog2(N);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic            carry;
   logic            zacc;

   logic            is_arith;
   logic            is_sub;
   logic            bb;
   logic            sum;
   logic            cout;
   logic            res;
   logic            last;

   always_comb begin
      is_sub   = (op_q == OP_SUB);
      is_arith = (op_q == OP_ADD) || is_sub;
      bb       = is_sub ? ~b_bit : b_bit;
      sum      = a_bit ^ bb ^ carry;
      cout     = (a_bit & bb) | (a_bit & carry) | (bb & carry);
      last     = (cnt == CW'(N - 1));
      case (op_q)
         OP_ADD, OP_SUB: res = sum;
         OP_AND:         res = a_bit & b_bit;
         OP_OR:          res = a_bit | b_bit;
         OP_XOR:         res = a_bit ^ b_bit;
         default:        res = b_bit;
      endcase
   end

   assign r_bit = r_valid ? res : 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= OP_ADD;
         carry   <= 1'b0;
         zacc    <= 1'b0;
         ready   <= 1'b1;
         r_valid <= 1'b0;
         done    <= 1'b0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         flag_lt <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_RUN;
                  op_q    <= op;
                  cnt     <= '0;
                  // SUB is A + ~B + 1: the +1 enters as the initial carry
                  carry   <= (op == OP_SUB);
                  zacc    <= 1'b1;
                  r_valid <= 1'b1;
                  ready   <= 1'b0;
               end else begin
                  state   <= S_IDLE;
                  r_valid <= 1'b0;
                  ready   <= 1'b1;
               end
            end
            S_RUN: begin
               cnt  <= cnt + CW'(1);
               zacc <= zacc & ~res;
               if (is_arith) begin
                  carry <= cout;
               end
               if (last) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  r_valid <= 1'b0;
                  ready   <= 1'b1;
                  flag_z  <= zacc & ~res;
                  flag_n  <= res;
                  flag_c  <= is_arith & cout;
                  flag_v  <= is_arith & (carry ^ cout);
                  flag_lt <= is_sub & (res ^ carry ^ cout);
               end
            end
            default: begin
               state   <= S_IDLE;
               r_valid <= 1'b0;
               ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
